// File: rtl/puf_eval_sequencer_if.sv
// PUF core attachment bundle: challenge and evaluation trigger toward the
// core, raw response and its single-cycle valid strobe back from it.
interface puf_eval_sequencer_if #(
  parameter int CHAL_WIDTH = 128,
  parameter int RESP_WIDTH = 128
);

  logic [CHAL_WIDTH-1:0] puf_challenge;
  logic                  puf_trigger;
  logic [RESP_WIDTH-1:0] puf_resp;
  logic                  puf_valid;

  // Sequencer side: drives the challenge and trigger, samples the response.
  modport master (
    output puf_challenge,
    output puf_trigger,
    input  puf_resp,
    input  puf_valid
  );

  // PUF core side.
  modport slave (
    input  puf_challenge,
    input  puf_trigger,
    output puf_resp,
    output puf_valid
  );

endinterface : puf_eval_sequencer_if

// File: rtl/puf_eval_sequencer.sv
// PUF evaluation sequencer.
// On a controller start it latches the challenge, then repeats REPEAT times:
// hold the challenge for SETTLE_CYCLES, pulse the trigger, wait for the
// response. Each response bit feeds its own ones-counter, and the final
// response is the per-bit majority. A missing response past TIMEOUT cycles
// ends the run with timeout_err set and an all-zero response.
module puf_eval_sequencer #(
  parameter int CHAL_WIDTH    = 128,
  parameter int RESP_WIDTH    = 128,
  parameter int SETTLE_CYCLES = 16,
  parameter int REPEAT        = 5,
  parameter int TIMEOUT       = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Controller side
  input  logic [CHAL_WIDTH-1:0] chal_in,
  input  logic                  chal_en,
  input  logic                  puf_start,
  output logic                  response_ready,
  output logic [RESP_WIDTH-1:0] response,
  output logic                  busy,
  output logic                  timeout_err,
  // PUF core side
  puf_eval_sequencer_if.master  puf
);

  // Counter widths. Each ones-counter tops out at REPEAT, so it never wraps.
  localparam int CW = $clog2(REPEAT + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] EVAL_LAST    = CW'(REPEAT - 1);
  // A bit votes 1 only with a strict majority; an even-REPEAT tie gives 0.
  localparam logic [CW-1:0] MAJ_THRESH   = CW'(REPEAT / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_TRIG,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                           r_puf_start_q;
  logic                           r_start_armed;
  logic [CHAL_WIDTH-1:0]          r_puf_challenge;
  logic                           r_puf_trigger;
  logic                           r_response_ready;
  logic [RESP_WIDTH-1:0]          r_response;
  logic                           r_timeout_err;
  logic [SW-1:0]                  r_settle_cnt;
  logic [TW-1:0]                  r_wait_cnt;
  logic [CW-1:0]                  r_eval_cnt;
  logic [RESP_WIDTH-1:0][CW-1:0]  r_ones;

  logic                  w_start_evt;
  logic                  w_accept;
  logic                  w_abort;
  logic                  w_settle_done;
  logic                  w_last_eval;
  logic                  w_timeout_hit;
  logic [RESP_WIDTH-1:0] w_vote;

  // A start is a 0->1 edge of puf_start. The arm flag only sets once a 0 has
  // been sampled, so a level already high when reset releases is not a start.
  assign w_start_evt   = puf_start & ~r_puf_start_q & r_start_armed;
  assign w_accept      = (r_state == S_IDLE) & w_start_evt & chal_en;
  assign w_abort       = (r_state != S_IDLE) & ~chal_en;
  assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
  assign w_last_eval   = (r_eval_cnt == EVAL_LAST);
  assign w_timeout_hit = (r_state == S_WAIT) & ~puf.puf_valid &
                         (r_wait_cnt == TIMEOUT_LAST);

  // Start-level history and arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_puf_start_q <= 1'b0;
      r_start_armed <= 1'b0;
    end else begin
      // NOTE: clocked state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      r_puf_start_q <= puf_start;
      r_start_armed <= r_start_armed | ~puf_start;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a dropped chal_en outranks every other transition.
  always_comb begin
    // NOTE: the default assignment first means every path drives the
    // signal, so no latch is inferred.
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept) w_next_state = S_SETTLE;
        S_SETTLE: if (w_settle_done) w_next_state = S_TRIG;
        S_TRIG:   w_next_state = S_WAIT;
        S_WAIT: begin
          if (puf.puf_valid) begin
            w_next_state = w_last_eval ? S_DONE : S_SETTLE;
          end else if (w_timeout_hit) begin
            w_next_state = S_DONE;
          end
        end
        S_DONE:   w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // Per-bit majority over the ones-counters.
  always_comb begin
    w_vote = '0;
    for (int i = 0; i < RESP_WIDTH; i++) begin
      w_vote[i] = (r_ones[i] > MAJ_THRESH);
    end
  end

  // Datapath: challenge latch, counters, trigger, result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_puf_challenge  <= '0;
      r_puf_trigger    <= 1'b0;
      r_response_ready <= 1'b0;
      r_response       <= '0;
      r_timeout_err    <= 1'b0;
      r_settle_cnt     <= '0;
      r_wait_cnt       <= '0;
      r_eval_cnt       <= '0;
      // NOTE: the counter array is reset too, so a run cut short by reset
      // leaves no stale votes behind for the next run.
      r_ones           <= '0;
    end else begin
      // The trigger is registered from the next state so it is a clean
      // one-cycle pulse coinciding exactly with TRIG.
      r_puf_trigger <= (w_next_state == S_TRIG);

      if (w_accept) begin
        r_puf_challenge  <= chal_in;
        r_response_ready <= 1'b0;
        r_timeout_err    <= 1'b0;
        r_settle_cnt     <= '0;
        r_wait_cnt       <= '0;
        r_eval_cnt       <= '0;
        r_ones           <= '0;
      end else if (w_abort) begin
        // Aborted run: no result is presented and the old response stays.
        r_response_ready <= 1'b0;
        r_settle_cnt     <= '0;
        r_wait_cnt       <= '0;
      end else begin
        case (r_state)
          S_SETTLE: begin
            r_settle_cnt <= w_settle_done ? '0 : r_settle_cnt + 1'b1;
          end
          S_TRIG: begin
            r_wait_cnt <= '0;
          end
          S_WAIT: begin
            if (puf.puf_valid) begin
              for (int i = 0; i < RESP_WIDTH; i++) begin
                r_ones[i] <= r_ones[i] + CW'(puf.puf_resp[i]);
              end
              r_eval_cnt <= r_eval_cnt + 1'b1;
            end else if (w_timeout_hit) begin
              r_timeout_err <= 1'b1;
              r_response    <= '0;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          S_DONE: begin
            // A timed-out run already forced the response to zero.
            if (!r_timeout_err) begin
              r_response <= w_vote;
            end
            r_response_ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign response_ready    = r_response_ready;
  assign response          = r_response;
  assign timeout_err       = r_timeout_err;
  assign puf.puf_challenge = r_puf_challenge;
  assign puf.puf_trigger   = r_puf_trigger;

endmodule : puf_eval_sequencer
